// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate back end.
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } mac_state_e;

  function automatic int unsigned acc_width(input int unsigned n, input int unsigned guard);
    return 2 * n + guard;
  endfunction

  localparam int unsigned ACC_W = acc_width(16, 8);

  // Saturation bounds for the default accumulator width.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1) {1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1) {1'b0}}};

endpackage

// File: rtl/mac_sat_add.sv
// Combinational two's-complement adder with signed-overflow detect.
// MAC_SATURATE_EN clamps the sum to the signed range instead of wrapping.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned Width = ACC_W
) (
  input  logic signed [Width-1:0] a_i,
  input  logic signed [Width-1:0] b_i,
  output logic signed [Width-1:0] sum_o,
  output logic                    ovf_o
);

  logic signed [Width-1:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[Width-1] == b_i[Width-1]) && (raw[Width-1] != a_i[Width-1]);
  end

`ifdef MAC_SATURATE_EN
  localparam logic [Width-1:0] SatMax = {1'b0, {(Width - 1) {1'b1}}};
  localparam logic [Width-1:0] SatMin = {1'b1, {(Width - 1) {1'b0}}};

  // Overflow direction follows the common operand sign.
  always_comb begin
    sum_o = raw;
    if (ovf_o) begin
      sum_o = a_i[Width-1] ? SatMin : SatMax;
    end
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Streaming MAC back end: sums len signed products, presents result on a held handshake.
// Build option MAC_SATURATE_EN selects clamping instead of wrapping on overflow.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned GUARD = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [LEN_W-1:0]                       len_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic signed [2*N-1:0]                  product_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic signed [acc_width(N, GUARD)-1:0]  result_o,
  output logic                                   busy_o,
  output logic                                   ovf_o
);

  localparam int unsigned AccW = acc_width(N, GUARD);

  mac_state_e              state_q, state_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic signed [AccW-1:0]  result_q, result_d;
  logic                    ovf_q, ovf_d;

  logic signed [AccW-1:0]  prod_ext;
  logic signed [AccW-1:0]  sum;
  logic                    add_ovf;

  assign prod_ext = AccW'(product_i);

  mac_sat_add #(
    .Width(AccW)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = len_i;
          acc_d   = '0;
          ovf_d   = 1'b0;
          if (len_i == '0) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          acc_d   = sum;
          count_d = count_q - LEN_W'(1);
          ovf_d   = ovf_q | add_ovf;
          if (count_q == LEN_W'(1)) begin
            result_d = sum;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = (state_q != StIdle);

endmodule
